// File: rtl/regfile_writeback.sv
// Write-side front end for the 32x32 register file: accepts load/ALU results, buffers them
// in order, drains one per cycle onto the single write port, and exposes pending values.
module regfile_writeback #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,

    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,

    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [1:0]        rf_reg_write,
    output logic [DATA_W-1:0] rf_write_data,

    input  logic [ADDR_W-1:0] byp_addr1,
    input  logic [ADDR_W-1:0] byp_addr2,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [DATA_W-1:0] byp_data1,
    output logic [DATA_W-1:0] byp_data2,

    output logic              wb_idle
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);
    localparam logic [1:0] RfWrite = 2'b01;
    localparam logic [1:0] RfIdle  = 2'b00;

    // Buffer storage needs no reset: occupancy is tracked solely by count_q.
    logic [ADDR_W-1:0] buf_reg  [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic              not_full;
    logic              mem_fire;
    logic              alu_fire;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_reg;
    logic [DATA_W-1:0] push_data;

    // Handshake and enqueue selection
    assign not_full  = (count_q < FullCount);
    assign mem_ready = not_full;
    assign alu_ready = not_full && !mem_valid;

    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;

    always_comb begin
        push_reg  = alu_reg;
        push_data = alu_data;
        if (mem_fire) begin
            push_reg  = mem_reg;
            push_data = mem_data;
        end
    end

    // Writes to r0 complete the handshake but are dropped here.
    assign push = (mem_fire || alu_fire) && (push_reg != '0);
    // Popping on the registered count keeps a fresh entry in the buffer for one cycle.
    assign pop  = (count_q != '0);

    // Pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_reg[wr_ptr_q]  <= push_reg;
            buf_data[wr_ptr_q] <= push_data;
        end
    end

    // Output stage driving the register file write port
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_reg_write  <= RfIdle;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else if (pop) begin
            rf_reg_write  <= RfWrite;
            rf_write_reg  <= buf_reg[rd_ptr_q];
            rf_write_data <= buf_data[rd_ptr_q];
        end else begin
            rf_reg_write  <= RfIdle;
        end
    end

    assign wb_idle = (count_q == '0) && (rf_reg_write == RfIdle);

    // Occupancy by age: slot i is the i-th oldest pending entry.
    logic [DEPTH-1:0] age_valid;
    always_comb begin
        age_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_valid[i] = ((PTR_W + 1)'(i) < count_q);
        end
    end

    logic [ADDR_W-1:0] look_addr [2];
    logic              look_hit  [2];
    logic [DATA_W-1:0] look_data [2];

    assign look_addr[0] = byp_addr1;
    assign look_addr[1] = byp_addr2;

    // Scan oldest to youngest so later matches override earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            look_hit[p]  = 1'b0;
            look_data[p] = '0;
            if (look_addr[p] != '0) begin
                if (rf_reg_write == RfWrite && rf_write_reg == look_addr[p]) begin
                    look_hit[p]  = 1'b1;
                    look_data[p] = rf_write_data;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    idx = rd_ptr_q + PTR_W'(i);
                    if (age_valid[i] && buf_reg[idx] == look_addr[p]) begin
                        look_hit[p]  = 1'b1;
                        look_data[p] = buf_data[idx];
                    end
                end
            end
        end
    end

    assign byp_hit1  = look_hit[0];
    assign byp_data1 = look_data[0];
    assign byp_hit2  = look_hit[1];
    assign byp_data2 = look_data[1];

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed stimulus with a commit-order scoreboard
// and explicit bypass/reset checks.
module tb_regfile_writeback;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              mem_valid, mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              alu_valid, alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [1:0]        rf_reg_write;
    logic [DATA_W-1:0] rf_write_data;
    logic [ADDR_W-1:0] byp_addr1, byp_addr2;
    logic              byp_hit1, byp_hit2;
    logic [DATA_W-1:0] byp_data1, byp_data2;
    logic              wb_idle;

    regfile_writeback #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_reg      (mem_reg),
        .mem_data     (mem_data),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .rf_write_reg (rf_write_reg),
        .rf_reg_write (rf_reg_write),
        .rf_write_data(rf_write_data),
        .byp_addr1    (byp_addr1),
        .byp_addr2    (byp_addr2),
        .byp_hit1     (byp_hit1),
        .byp_hit2     (byp_hit2),
        .byp_data1    (byp_data1),
        .byp_data2    (byp_data2),
        .wb_idle      (wb_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: {reg, data} pushed on acceptance, popped when the write port fires.
    logic [ADDR_W+DATA_W-1:0] sb[$];

    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] exp;
        if (rf_reg_write == 2'b01) begin
            if (sb.size() == 0) begin
                check("commit_unexpected", {27'd0, rf_write_reg, rf_write_data}, 64'd0);
            end else begin
                exp = sb.pop_front();
                check("commit_reg", 64'(rf_write_reg), 64'(exp[ADDR_W+DATA_W-1:DATA_W]));
                check("commit_data", 64'(rf_write_data), 64'(exp[DATA_W-1:0]));
            end
        end else if (rf_reg_write != 2'b00) begin
            check("rf_reg_write_code", 64'(rf_reg_write), 64'd0);
        end
        if (rst) begin
            sb.delete();
        end else if (mem_valid && mem_ready) begin
            if (mem_reg != '0) sb.push_back({mem_reg, mem_data});
        end else if (alu_valid && alu_ready) begin
            if (alu_reg != '0) sb.push_back({alu_reg, alu_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        byp_addr1 = '0; byp_addr2 = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rf_reg_write", 64'(rf_reg_write), 64'd0);
        check("rst_rf_write_reg", 64'(rf_write_reg), 64'd0);
        check("rst_rf_write_data", 64'(rf_write_data), 64'd0);
        check("rst_wb_idle", 64'(wb_idle), 64'd1);
        check("rst_mem_ready", 64'(mem_ready), 64'd1);
        check("rst_alu_ready", 64'(alu_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_wb_idle", 64'(wb_idle), 64'd1);
            check("idle_rf_reg_write", 64'(rf_reg_write), 64'd0);
        end

        // Single ALU write
        tick();
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        check("single_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0; byp_addr1 = 5'd5;
        @(negedge clk);
        check("single_byp_hit_buf", 64'(byp_hit1), 64'd1);
        check("single_byp_data_buf", 64'(byp_data1), 64'hDEADBEEF);
        check("single_not_yet", 64'(rf_reg_write), 64'd0);
        tick();
        @(negedge clk);
        check("single_rf_reg_write", 64'(rf_reg_write), 64'd1);
        check("single_rf_write_reg", 64'(rf_write_reg), 64'd5);
        check("single_rf_write_data", 64'(rf_write_data), 64'hDEADBEEF);
        check("single_byp_hit_out", 64'(byp_hit1), 64'd1);
        check("single_byp_data_out", 64'(byp_data1), 64'hDEADBEEF);
        tick();
        @(negedge clk);
        check("single_after_rf", 64'(rf_reg_write), 64'd0);
        check("single_after_hit", 64'(byp_hit1), 64'd0);
        check("single_after_data", 64'(byp_data1), 64'd0);
        check("single_after_idle", 64'(wb_idle), 64'd1);

        // Load priority over ALU, back-to-back stream
        for (int k = 1; k <= 6; k++) begin
            tick();
            mem_valid = 1'b1; mem_reg = 5'(k); mem_data = 32'h100 + 32'(k);
            alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'hBAD;
            @(negedge clk);
            check("prio_alu_ready", 64'(alu_ready), 64'd0);
            check("prio_mem_ready", 64'(mem_ready), 64'd1);
        end
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        for (int i = 0; i < 20 && !(sb.size() == 0 && wb_idle); i++) @(negedge clk);
        check("prio_drained", 64'(sb.size() == 0 && wb_idle), 64'd1);

        // Youngest-wins bypass
        tick();
        alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h11; byp_addr2 = 5'd7;
        tick();
        alu_data = 32'h22;
        tick();
        alu_data = 32'h33;
        @(negedge clk);
        check("young_hit_2nd", 64'(byp_hit2), 64'd1);
        check("young_data_2nd", 64'(byp_data2), 64'h22);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("young_data_3rd", 64'(byp_data2), 64'h33);
        tick();
        @(negedge clk);
        check("young_hit_out", 64'(byp_hit2), 64'd1);
        check("young_data_out", 64'(byp_data2), 64'h33);
        tick();
        @(negedge clk);
        check("young_hit_gone", 64'(byp_hit2), 64'd0);
        check("young_data_gone", 64'(byp_data2), 64'd0);

        // Register zero
        tick();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFFFFFF; byp_addr1 = 5'd0;
        @(negedge clk);
        check("r0_alu_ready", 64'(alu_ready), 64'd1);
        check("r0_byp_hit", 64'(byp_hit1), 64'd0);
        check("r0_byp_data", 64'(byp_data1), 64'd0);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("r0_wb_idle", 64'(wb_idle), 64'd1);
        tick();
        @(negedge clk);
        check("r0_no_write", 64'(rf_reg_write), 64'd0);

        // Reset mid-stream
        tick();
        mem_valid = 1'b1; mem_reg = 5'd10; mem_data = 32'hA0;
        tick();
        mem_reg = 5'd11; mem_data = 32'hA1;
        tick();
        mem_reg = 5'd12; mem_data = 32'hA2;
        tick();
        mem_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_wb_idle", 64'(wb_idle), 64'd1);
        check("midrst_rf_reg_write", 64'(rf_reg_write), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_quiet", 64'(rf_reg_write), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
